// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect inputs, instruction-memory handshake
// and the IF/ID register outputs seen by decode.
interface fetch_stage_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pcOut;
    logic [31:0] instruction;
    logic        valid;

    // Fetch stage side.
    modport master (
        input  stall, branch_taken, branch_target, imem_ready, imem_rdata,
        output imem_req, imem_addr, pcOut, instruction, valid
    );

    // Environment side: hazard unit, branch unit, instruction memory, decode.
    modport slave (
        output stall, branch_taken, branch_target, imem_ready, imem_rdata,
        input  imem_req, imem_addr, pcOut, instruction, valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, one-entry skid buffer for
// hazard stalls and redirect handling that never withdraws an in-flight
// memory request.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        FETCH,
        BUFFERED,
        DISCARD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] saved_q, saved_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;

    logic        accept;
    logic        flush;
    logic [31:0] target;
    logic [31:0] pc_next;

    assign accept  = req_q && bus.imem_ready;
    assign target  = {bus.branch_target[31:2], 2'b00};
    assign pc_next = pc_q + STEP;

    // Next-state, PC and IF/ID update; branch outranks stall everywhere.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        saved_d  = saved_q;
        skid_d   = skid_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        flush    = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (accept) begin
                    if (bus.branch_taken) begin
                        pc_d  = target;
                        flush = 1'b1;
                    end else if (bus.stall) begin
                        skid_d  = bus.imem_rdata;
                        state_d = BUFFERED;
                    end else begin
                        pc_out_d = pc_next;
                        instr_d  = bus.imem_rdata;
                        valid_d  = 1'b1;
                        pc_d     = pc_next;
                    end
                end else if (bus.branch_taken) begin
                    // Request at the old PC is still in flight: remember the
                    // target and drop the response when it arrives.
                    saved_d = target;
                    flush   = 1'b1;
                    state_d = DISCARD;
                end else if (!bus.stall) begin
                    valid_d = 1'b0;
                end
            end
            BUFFERED: begin
                if (bus.branch_taken) begin
                    pc_d    = target;
                    skid_d  = '0;
                    flush   = 1'b1;
                    state_d = FETCH;
                end else if (!bus.stall) begin
                    pc_out_d = pc_next;
                    instr_d  = skid_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_next;
                    skid_d   = '0;
                    state_d  = FETCH;
                end
            end
            DISCARD: begin
                flush = 1'b1;
                if (bus.branch_taken) begin
                    saved_d = target;
                end
                if (accept) begin
                    // Newest redirect wins even in the accept cycle.
                    pc_d    = bus.branch_taken ? target : saved_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (flush) begin
            pc_out_d = '0;
            instr_d  = '0;
            valid_d  = 1'b0;
        end

        req_d = (state_d != BUFFERED);
    end

    // State and output registers; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            saved_q  <= '0;
            skid_q   <= '0;
            pc_out_q <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            req_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            saved_q  <= saved_d;
            skid_q   <= skid_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            req_q    <= req_d;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.pcOut       = pc_out_q;
    assign bus.instruction = instr_q;
    assign bus.valid       = valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns address-as-data, expected
// IF/ID entries are queued when a deliverable fetch is accepted and popped
// when the stage presents a new entry.
module tb_fetch_stage;
    localparam int K_HOLD    = 0;
    localparam int K_DELIVER = 1;
    localparam int K_FLUSH   = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;

    logic   clk;
    logic   reset;
    int     checks;
    int     failures;
    entry_t sb[$];
    entry_t last;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check request/address, then check IF/ID.
    task automatic cyc(input logic st, input logic br, input logic [31:0] tgt,
                       input logic rdy, input logic [31:0] exp_addr,
                       input logic exp_req, input logic push, input int kind,
                       input logic exp_valid);
        entry_t e;
        bus.stall         = st;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        bus.imem_ready    = rdy;
        bus.imem_rdata    = bus.imem_addr;
        chk("imem_addr", bus.imem_addr, exp_addr);
        chk("imem_req", {31'b0, bus.imem_req}, {31'b0, exp_req});
        if (push) begin
            e.pc  = exp_addr + 32'd4;
            e.ins = exp_addr;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("valid", {31'b0, bus.valid}, {31'b0, exp_valid});
        if (kind == K_DELIVER) begin
            chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) last = sb.pop_front();
        end else if (kind == K_FLUSH) begin
            last = '0;
        end
        chk("pcOut", bus.pcOut, last.pc);
        chk("instruction", bus.instruction, last.ins);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        last     = '0;
        reset    = 1'b1;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = '0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, bus.valid}, 32'd0);
        chk("rst_pcOut", bus.pcOut, 32'd0);
        chk("rst_instr", bus.instruction, 32'd0);
        reset = 1'b0;
        chk("rst_addr", bus.imem_addr, 32'd0);
        chk("rst_req", {31'b0, bus.imem_req}, 32'd1);

        // 1: zero-wait streaming.
        cyc(0, 0, 0, 1, 32'h0,  1, 1, K_DELIVER, 1);
        cyc(0, 0, 0, 1, 32'h4,  1, 1, K_DELIVER, 1);
        cyc(0, 0, 0, 1, 32'h8,  1, 1, K_DELIVER, 1);
        cyc(0, 0, 0, 1, 32'hC,  1, 1, K_DELIVER, 1);

        // 2: three wait cycles per request.
        for (int n = 0; n < 2; n++) begin
            for (int w = 0; w < 3; w++)
                cyc(0, 0, 0, 0, 32'h10 + 32'(4 * n), 1, 0, K_HOLD, 0);
            cyc(0, 0, 0, 1, 32'h10 + 32'(4 * n), 1, 1, K_DELIVER, 1);
        end

        // 3: stall across acceptance of 0x18; ready ignored while req low.
        cyc(1, 0, 0, 1, 32'h18, 1, 1, K_HOLD, 1);
        for (int w = 0; w < 3; w++)
            cyc(1, 0, 0, 1, 32'h18, 0, 0, K_HOLD, 1);
        cyc(0, 0, 0, 0, 32'h18, 0, 0, K_DELIVER, 1);
        cyc(0, 0, 0, 1, 32'h1C, 1, 1, K_DELIVER, 1);

        // 4: branch to unaligned 0x103 while the 0x20 request waits.
        cyc(0, 1, 32'h103, 0, 32'h20, 1, 0, K_FLUSH, 0);
        cyc(0, 0, 0,       0, 32'h20, 1, 0, K_FLUSH, 0);
        cyc(0, 0, 0,       1, 32'h20, 1, 0, K_FLUSH, 0);
        cyc(0, 0, 0,       1, 32'h100, 1, 1, K_DELIVER, 1);

        // 4b: second branch in the discard accept cycle wins.
        cyc(0, 1, 32'h300, 0, 32'h104, 1, 0, K_FLUSH, 0);
        cyc(0, 1, 32'h40B, 1, 32'h104, 1, 0, K_FLUSH, 0);
        cyc(0, 0, 0,       1, 32'h408, 1, 1, K_DELIVER, 1);

        // 5: branch and stall together at acceptance.
        cyc(1, 1, 32'h50, 1, 32'h40C, 1, 0, K_FLUSH, 0);
        cyc(0, 0, 0,      1, 32'h50,  1, 1, K_DELIVER, 1);
        // 5b: branch while buffered discards the skid word.
        cyc(1, 0, 0,      1, 32'h54,  1, 0, K_HOLD, 1);
        cyc(1, 1, 32'h80, 1, 32'h54,  0, 0, K_FLUSH, 0);
        cyc(0, 0, 0,      1, 32'h80,  1, 1, K_DELIVER, 1);

        // PC wrap at the top of the address space.
        cyc(0, 1, 32'hFFFF_FFFC, 1, 32'h84, 1, 0, K_FLUSH, 0);
        cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 1, K_DELIVER, 1);
        cyc(0, 0, 0, 1, 32'h0,         1, 1, K_DELIVER, 1);

        // 6: reset while buffered.
        cyc(1, 0, 0, 1, 32'h4, 1, 0, K_HOLD, 1);
        cyc(1, 0, 0, 0, 32'h4, 0, 0, K_HOLD, 1);
        bus.stall = 1'b0;
        bus.imem_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("async_valid", {31'b0, bus.valid}, 32'd0);
        chk("async_pcOut", bus.pcOut, 32'd0);
        chk("async_instr", bus.instruction, 32'd0);
        chk("async_addr", bus.imem_addr, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        last = '0;
        cyc(0, 0, 0, 0, 32'h0, 1, 0, K_HOLD, 0);
        cyc(0, 0, 0, 1, 32'h0, 1, 1, K_DELIVER, 1);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        bus.imem_ready = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
